// File: rtl/fir_stream_if.sv
// Stream, coefficient-load and status signals of the transposed FIR filter.
// master = sample source / sink / controller side, slave = filter side.
interface fir_stream_if #(
   parameter int NTAPS  = 32,
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int OUT_W  = 16
);
   localparam int AW = $clog2(NTAPS);

   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [OUT_W-1:0]  out_data;
   logic                     coef_wr_en;
   logic [AW-1:0]            coef_wr_addr;
   logic signed [COEF_W-1:0] coef_wr_data;
   logic                     coef_commit;
   logic                     flush;
   logic                     sat_sticky;
   logic                     sat_clear;

   modport master (
      output in_valid, in_data, out_ready,
      output coef_wr_en, coef_wr_addr, coef_wr_data, coef_commit,
      output flush, sat_clear,
      input  in_ready, out_valid, out_data, sat_sticky
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      input  coef_wr_en, coef_wr_addr, coef_wr_data, coef_commit,
      input  flush, sat_clear,
      output in_ready, out_valid, out_data, sat_sticky
   );
endinterface

// File: rtl/fir_transposed_stream.sv
// Transposed-form FIR with valid/ready streaming, double-buffered coefficients,
// round-half-up scaling with saturation, and a synchronous state flush.
module fir_transposed_stream #(
   parameter int NTAPS     = 32,
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 16,
   parameter int OUT_W     = 16,
   parameter int OUT_SHIFT = 15
) (
   input  logic          clk,
   input  logic          reset,
   fir_stream_if.slave   bus
);
   localparam int ACC_W  = DATA_W + COEF_W + $clog2(NTAPS);
   localparam int AW     = $clog2(NTAPS);
   localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

   localparam logic signed [ACC_W:0]   RND     = (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;
   localparam logic signed [ACC_W:0]   MAX_EXT = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0]   MIN_EXT = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   logic signed [COEF_W-1:0] coef_shadow [NTAPS];
   logic signed [COEF_W-1:0] coef_active [NTAPS];
   logic signed [ACC_W-1:0]  acc [NTAPS-1];
   logic signed [ACC_W-1:0]  prod [NTAPS];
   logic signed [ACC_W-1:0]  x_ext;
   logic signed [ACC_W:0]    y_full;
   logic signed [ACC_W:0]    y_rnd;
   logic signed [ACC_W:0]    y_scaled;
   logic signed [OUT_W-1:0]  y_sat;
   logic signed [OUT_W-1:0]  out_data_q;
   logic                     sat_hit;
   logic                     out_valid_q;
   logic                     sat_q;
   logic                     in_ready;
   logic                     acc_fire;
   logic                     addr_ok;

   assign in_ready       = !out_valid_q || bus.out_ready;
   assign acc_fire       = bus.in_valid && in_ready;
   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.sat_sticky = sat_q;

   assign x_ext = ACC_W'($signed(bus.in_data));

   generate
      if ((1 << AW) == NTAPS) begin : g_addr_full
         assign addr_ok = 1'b1;
      end else begin : g_addr_range
         assign addr_ok = (int'(bus.coef_wr_addr) < NTAPS);
      end
   endgenerate

   // Accumulator width covers NTAPS full-scale products; one extra bit leaves room for rounding.
   always_comb begin
      for (int k = 0; k < NTAPS; k++) begin
         prod[k] = ACC_W'($signed(coef_active[k])) * x_ext;
      end
      y_full   = {prod[0][ACC_W-1], prod[0]} + {acc[0][ACC_W-1], acc[0]};
      y_rnd    = y_full + RND;
      y_scaled = y_rnd >>> OUT_SHIFT;
      sat_hit  = 1'b1;
      if (y_scaled > MAX_EXT) begin
         y_sat = OUT_MAX;
      end else if (y_scaled < MIN_EXT) begin
         y_sat = OUT_MIN;
      end else begin
         y_sat   = y_scaled[OUT_W-1:0];
         sat_hit = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NTAPS; k++) begin
            coef_shadow[k] <= '0;
            coef_active[k] <= '0;
         end
         for (int k = 0; k < NTAPS-1; k++) begin
            acc[k] <= '0;
         end
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         // A commit in the same cycle as a write copies the pre-write shadow contents.
         if (bus.coef_wr_en && addr_ok) begin
            coef_shadow[bus.coef_wr_addr] <= bus.coef_wr_data;
         end
         if (bus.coef_commit) begin
            for (int k = 0; k < NTAPS; k++) begin
               coef_active[k] <= coef_shadow[k];
            end
         end

         if (bus.flush) begin
            for (int k = 0; k < NTAPS-1; k++) begin
               acc[k] <= '0;
            end
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
         end else if (acc_fire) begin
            for (int k = 0; k < NTAPS-2; k++) begin
               acc[k] <= prod[k+1] + acc[k+1];
            end
            acc[NTAPS-2] <= prod[NTAPS-1];
            out_data_q   <= y_sat;
            out_valid_q  <= 1'b1;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         if (!bus.flush && acc_fire && sat_hit) begin
            sat_q <= 1'b1;
         end else if (bus.sat_clear) begin
            sat_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fir_transposed_stream.sv
// Directed bench: 8-tap unscaled filter for stream/coef/flush/saturation cases,
// 2-tap filter with OUT_SHIFT=1 for rounding.
module tb_fir_transposed_stream;
   localparam int NA = 8;

   typedef struct {
      int x;
      int y;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fir_stream_if #(.NTAPS(NA), .DATA_W(16), .COEF_W(16), .OUT_W(16)) bus_a ();
   fir_stream_if #(.NTAPS(2),  .DATA_W(16), .COEF_W(16), .OUT_W(16)) bus_b ();

   fir_transposed_stream #(.NTAPS(NA), .DATA_W(16), .COEF_W(16), .OUT_W(16), .OUT_SHIFT(0))
      dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   fir_transposed_stream #(.NTAPS(2), .DATA_W(16), .COEF_W(16), .OUT_W(16), .OUT_SHIFT(1))
      dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr_a(input int addr, input int val);
      bus_a.coef_wr_en   = 1'b1;
      bus_a.coef_wr_addr = addr[2:0];
      bus_a.coef_wr_data = 16'(val);
      tick();
      bus_a.coef_wr_en   = 1'b0;
   endtask

   task automatic commit_a();
      bus_a.coef_commit = 1'b1;
      tick();
      bus_a.coef_commit = 1'b0;
   endtask

   task automatic flush_a();
      bus_a.flush = 1'b1;
      tick();
      bus_a.flush = 1'b0;
   endtask

   task automatic send_a(input string nm, input int x, input int exp);
      bus_a.out_ready = 1'b1;
      bus_a.in_valid  = 1'b1;
      bus_a.in_data   = 16'(x);
      tick();
      bus_a.in_valid  = 1'b0;
      check({nm, "_valid"}, longint'(bus_a.out_valid), 1);
      check(nm, longint'(bus_a.out_data), exp);
   endtask

   task automatic send_b(input string nm, input int x, input int exp);
      bus_b.out_ready = 1'b1;
      bus_b.in_valid  = 1'b1;
      bus_b.in_data   = 16'(x);
      tick();
      bus_b.in_valid  = 1'b0;
      check({nm, "_valid"}, longint'(bus_b.out_valid), 1);
      check(nm, longint'(bus_b.out_data), exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t imp [16];
      vec_t rnd [9];
      int   xs [12];
      int   hist [NA];
      int   i, consumed, exp_data;
      bit   exp_valid, exp_ready;
      longint y;

      for (int k = 0; k < 16; k++) begin
         imp[k].x = (k == 0) ? 1 : 0;
         imp[k].y = (k < NA) ? k + 1 : 0;
      end
      rnd[0] = '{3, 2};      rnd[1] = '{-3, -1};   rnd[2] = '{1, 1};
      rnd[3] = '{0, 0};      rnd[4] = '{-1, 0};    rnd[5] = '{2, 1};
      rnd[6] = '{-2, -1};    rnd[7] = '{32767, 16384};
      rnd[8] = '{-32768, -16384};
      xs = '{100, -200, 300, 50, -7, 0, 400, -450, 12, 250, -300, 99};

      bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.out_ready = 0;
      bus_a.coef_wr_en = 0; bus_a.coef_wr_addr = '0; bus_a.coef_wr_data = '0;
      bus_a.coef_commit = 0; bus_a.flush = 0; bus_a.sat_clear = 0;
      bus_b.in_valid = 0; bus_b.in_data = '0; bus_b.out_ready = 0;
      bus_b.coef_wr_en = 0; bus_b.coef_wr_addr = '0; bus_b.coef_wr_data = '0;
      bus_b.coef_commit = 0; bus_b.flush = 0; bus_b.sat_clear = 0;

      // reset state
      #12;
      check("rst_a_out_valid", longint'(bus_a.out_valid), 0);
      check("rst_a_out_data", longint'(bus_a.out_data), 0);
      check("rst_a_in_ready", longint'(bus_a.in_ready), 1);
      check("rst_a_sat", longint'(bus_a.sat_sticky), 0);
      check("rst_b_out_valid", longint'(bus_b.out_valid), 0);
      check("rst_b_in_ready", longint'(bus_b.in_ready), 1);
      @(negedge clk);
      reset = 1'b0;
      tick();

      send_a("zero_coef", 5, 0);

      // rounding on the 2-tap, shift-by-1 filter
      bus_b.coef_wr_en = 1; bus_b.coef_wr_addr = 1'b0; bus_b.coef_wr_data = 16'sd1;
      tick();
      bus_b.coef_wr_en = 0; bus_b.coef_commit = 1;
      tick();
      bus_b.coef_commit = 0;
      for (int k = 0; k < 9; k++) send_b($sformatf("round_%0d", rnd[k].x), rnd[k].x, rnd[k].y);

      // impulse response with coef[k] = k+1
      for (int k = 0; k < NA; k++) wr_a(k, k + 1);
      commit_a();
      flush_a();
      for (int k = 0; k < 16; k++) send_a($sformatf("impulse_%0d", k), imp[k].x, imp[k].y);
      tick();
      check("impulse_drain_valid", longint'(bus_a.out_valid), 0);

      // backpressure against a direct-form golden model
      flush_a();
      for (int k = 0; k < NA; k++) hist[k] = 0;
      i = 0; consumed = 0; exp_valid = 0; exp_data = 0;
      for (int cyc = 0; cyc < 40 && consumed < 12; cyc++) begin
         check("bp_out_valid", longint'(bus_a.out_valid), longint'(exp_valid));
         if (exp_valid) check("bp_out_data", longint'(bus_a.out_data), exp_data);
         bus_a.out_ready = !(cyc >= 3 && cyc < 6);
         bus_a.in_valid  = (i < 12);
         bus_a.in_data   = (i < 12) ? 16'(xs[i]) : '0;
         exp_ready = !exp_valid || bus_a.out_ready;
         #1;
         check("bp_in_ready", longint'(bus_a.in_ready), longint'(exp_ready));
         if (exp_valid && bus_a.out_ready) consumed++;
         if (bus_a.in_valid && exp_ready) begin
            for (int k = NA-1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = xs[i];
            y = 0;
            for (int k = 0; k < NA; k++) y += longint'(k + 1) * hist[k];
            exp_data  = (y > 32767) ? 32767 : (y < -32768) ? -32768 : int'(y);
            exp_valid = 1;
            i++;
         end else if (bus_a.out_ready) begin
            exp_valid = 0;
         end
         @(posedge clk);
         @(negedge clk);
      end
      check("bp_consumed", consumed, 12);
      bus_a.in_valid = 0; bus_a.out_ready = 1;
      tick();

      // saturation and sticky flag
      for (int k = 0; k < NA; k++) wr_a(k, 32767);
      commit_a();
      flush_a();
      send_a("sat_pos", 32767, 32767);
      check("sat_pos_sticky", longint'(bus_a.sat_sticky), 1);
      flush_a();
      check("flush_keeps_sat", longint'(bus_a.sat_sticky), 1);
      bus_a.sat_clear = 1;
      tick();
      bus_a.sat_clear = 0;
      check("sat_cleared", longint'(bus_a.sat_sticky), 0);
      send_a("sat_zero", 0, 0);
      check("sat_zero_sticky", longint'(bus_a.sat_sticky), 0);
      send_a("sat_neg", -32768, -32768);
      check("sat_neg_sticky", longint'(bus_a.sat_sticky), 1);
      bus_a.sat_clear = 1;
      send_a("sat_clear_race", -32768, -32768);
      bus_a.sat_clear = 0;
      check("sat_clear_race_sticky", longint'(bus_a.sat_sticky), 1);

      // commit racing an accepted sample, and a write racing a commit
      wr_a(0, 1);
      for (int k = 1; k < NA; k++) wr_a(k, 0);
      commit_a();
      flush_a();
      wr_a(0, 2);
      bus_a.coef_commit = 1;
      send_a("commit_race_old", 5, 5);
      bus_a.coef_commit = 0;
      send_a("commit_race_new", 5, 10);
      bus_a.coef_wr_en = 1; bus_a.coef_wr_addr = 3'd0; bus_a.coef_wr_data = 16'sd3;
      bus_a.coef_commit = 1;
      tick();
      bus_a.coef_wr_en = 0; bus_a.coef_commit = 0;
      send_a("wr_commit_race", 5, 10);
      commit_a();
      send_a("late_commit", 5, 15);

      // flush mid-stream; sample presented in the flush cycle is dropped
      for (int k = 0; k < NA; k++) wr_a(k, k + 1);
      commit_a();
      flush_a();
      send_a("flush_pre0", 1, 1);
      send_a("flush_pre1", 0, 2);
      send_a("flush_pre2", 0, 3);
      bus_a.flush = 1; bus_a.in_valid = 1; bus_a.in_data = 16'sd1; bus_a.out_ready = 1;
      #1;
      check("flush_in_ready", longint'(bus_a.in_ready), 1);
      @(posedge clk);
      @(negedge clk);
      bus_a.flush = 0; bus_a.in_valid = 0;
      check("flush_out_valid", longint'(bus_a.out_valid), 0);
      check("flush_out_data", longint'(bus_a.out_data), 0);
      for (int k = 0; k < 3; k++) send_a($sformatf("flush_post%0d", k), 0, 0);

      // asynchronous reset in the middle of a burst
      send_a("burst0", 1, 1);
      bus_a.in_valid = 1; bus_a.in_data = '0;
      tick();
      check("burst1", longint'(bus_a.out_data), 2);
      #2 reset = 1'b1;
      #1;
      check("arst_out_valid", longint'(bus_a.out_valid), 0);
      check("arst_out_data", longint'(bus_a.out_data), 0);
      check("arst_in_ready", longint'(bus_a.in_ready), 1);
      check("arst_sat", longint'(bus_a.sat_sticky), 0);
      @(negedge clk);
      reset = 1'b0;
      bus_a.in_valid = 0;
      tick();
      send_a("arst_coef_cleared", 1, 0);
      wr_a(0, 7);
      commit_a();
      send_a("arst_reload", 2, 14);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
